// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped switch/key/LED controller with sticky key events and a maskable irq.
// Define GPIO_DEBOUNCE_EN to build the per-key debounce counters; otherwise keys follow the synchroniser.
module gpio_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7F50,
    parameter int          SW_GROUPS    = 8,
    parameter int          KEY_W        = 8,
    parameter int          LED_W        = 32,
    parameter int          DEBOUNCE_CYC = 20000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            addr_in,
    input  logic [31:0]            data_in,
    input  logic [3:0]             byteen,
    output logic [31:0]            data_out,
    input  logic [8*SW_GROUPS-1:0] dip_sw_n,
    input  logic [KEY_W-1:0]       key_n,
    output logic [LED_W-1:0]       led_n,
    output logic                   irq
);
    logic [8*SW_GROUPS-1:0] sw_s1, sw_s2;
    logic [KEY_W-1:0] key_s1, key_s2, key_lvl, rise, edge_flags, irq_mask, clr;
    logic [LED_W-1:0] led;
    logic [29:0] word;
    logic [31:0] bm;
    logic [63:0] sw_all;
    logic in_win, wr, unused_bits;

    assign word   = addr_in[31:2] - BASE_ADDR[31:2];
    assign in_win = word < 30'd6;
    assign wr     = in_win && |byteen;
    assign bm     = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
    assign clr    = (wr && word == 30'd3) ? data_in[KEY_W-1:0] & bm[KEY_W-1:0] : '0;
    assign sw_all = 64'(~sw_s2);
    assign led_n  = ~led;
    assign unused_bits = ^{addr_in[1:0], data_in, bm, DEBOUNCE_CYC > 1};

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            sw_s1  <= dip_sw_n;
            sw_s2  <= sw_s1;
            key_s1 <= key_n;
            key_s2 <= key_s1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC);
    logic [KEY_W-1:0] stable, stable_nxt, key_sync;
    logic [CW-1:0] cnt [KEY_W];
    logic [CW-1:0] cnt_nxt [KEY_W];

    assign key_sync = ~key_s2;

    // Any agreement with the accepted level restarts the count, so short glitches never land.
    always_comb begin
        for (int i = 0; i < KEY_W; i++) begin
            cnt_nxt[i]    = (key_sync[i] != stable[i] && cnt[i] != CW'(DEBOUNCE_CYC - 1)) ? cnt[i] + 1'b1 : '0;
            stable_nxt[i] = (key_sync[i] != stable[i] && cnt[i] == CW'(DEBOUNCE_CYC - 1)) ? key_sync[i] : stable[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            cnt    <= '{default: '0};
        end else begin
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign key_lvl = stable;
    assign rise    = stable_nxt & ~stable;
`else
    assign key_lvl = ~key_s2;
    assign rise    = ~key_s1 & key_s2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            led        <= '0;
            irq_mask   <= '0;
            edge_flags <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr && word == 30'd4)
                led <= (led & ~bm[LED_W-1:0]) | (data_in[LED_W-1:0] & bm[LED_W-1:0]);
            if (wr && word == 30'd5)
                irq_mask <= (irq_mask & ~bm[KEY_W-1:0]) | (data_in[KEY_W-1:0] & bm[KEY_W-1:0]);
            edge_flags <= (edge_flags & ~clr) | rise;
            irq        <= |(edge_flags & irq_mask);
        end
    end

    always_comb begin
        data_out = !in_win          ? '0 :
                   word == 30'd0    ? sw_all[31:0] :
                   word == 30'd1    ? sw_all[63:32] :
                   word == 30'd2    ? 32'(key_lvl) :
                   word == 30'd3    ? 32'(edge_flags) :
                   word == 30'd4    ? 32'(led) : 32'(irq_mask);
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: table vectors, directed key/switch sequences and a random run against a register-level model.
// Works with or without GPIO_DEBOUNCE_EN defined.
module tb_gpio_ctrl;
    localparam logic [31:0] BASE = 32'h0000_7F50;
    localparam int D = 4, K = 8, L = 32;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + D;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] addr_in = '0, data_in = '0, data_out;
    logic [3:0] byteen = '0;
    logic [63:0] dip_sw_n = '1;
    logic [K-1:0] key_n = '1;
    logic [L-1:0] led_n;
    logic irq;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    gpio_ctrl #(.BASE_ADDR(BASE), .SW_GROUPS(8), .KEY_W(K), .LED_W(L), .DEBOUNCE_CYC(D)) dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .byteen(byteen),
        .data_out(data_out), .dip_sw_n(dip_sw_n), .key_n(key_n), .led_n(led_n), .irq(irq)
    );

    // Reference model: pin pipelines, a window of recent synced samples, and the register file.
    logic [63:0] m_sp0, m_sp1;
    logic [K-1:0] m_kp0, m_kp1, m_stable, m_flags, m_mask, m_sync, m_ns, m_rise, m_clr, m_lvl;
    logic [K-1:0] m_hist [D];
    logic [L-1:0] m_led;
    logic [31:0] m_bm;
    logic m_irq, m_wr;
    int m_w;

    function automatic int woff(input logic [31:0] a);
        longint o;
        o = longint'({32'b0, a[31:2], 2'b00}) - longint'({32'b0, BASE});
        return (o >= 0 && o < 24) ? int'(o / 4) : -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (woff(a))
            0: return ~m_sp1[31:0];
            1: return ~m_sp1[63:32];
            2: return 32'(m_lvl);
            3: return 32'(m_flags);
            4: return m_led;
            5: return 32'(m_mask);
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        logic all_diff, smp;
        all_diff = 1'b0;
        smp = 1'b0;
        m_sync = ~m_kp1;
        m_ns = m_stable;
        for (int i = 0; i < K; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
                smp = (j == 0) ? m_sync[i] : m_hist[j-1][i];
                all_diff = all_diff & (smp != m_stable[i]);
            end
            m_ns[i] = all_diff ? m_sync[i] : m_stable[i];
        end
`ifdef GPIO_DEBOUNCE_EN
        m_rise = m_ns & ~m_stable;
        m_lvl = m_stable;
`else
        m_rise = ~m_kp0 & m_kp1;
        m_lvl = ~m_kp1;
`endif
        m_w = woff(addr_in);
        m_wr = m_w >= 0 && byteen != 4'b0;
        m_bm = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
        m_clr = (m_wr && m_w == 3) ? data_in[K-1:0] & m_bm[K-1:0] : '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_sp0 <= '0; m_sp1 <= '0; m_kp0 <= '0; m_kp1 <= '0;
            m_stable <= '0; m_flags <= '0; m_mask <= '0; m_led <= '0; m_irq <= 1'b0;
            m_hist <= '{default: '0};
        end else begin
            m_sp0 <= dip_sw_n; m_sp1 <= m_sp0; m_kp0 <= key_n; m_kp1 <= m_kp0;
            m_hist[0] <= m_sync;
            for (int j = 1; j < D; j++) m_hist[j] <= m_hist[j-1];
            m_stable <= m_ns;
            if (m_wr && m_w == 4) m_led <= (m_led & ~m_bm) | (data_in & m_bm);
            if (m_wr && m_w == 5) m_mask <= (m_mask & ~m_bm[K-1:0]) | (data_in[K-1:0] & m_bm[K-1:0]);
            m_flags <= (m_flags & ~m_clr) | m_rise;
            m_irq <= |(m_flags & m_mask);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr_in = a; data_in = d; byteen = be;
        cyc(1);
        byteen = '0; data_in = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr_in = a;
        #1;
        check(name, data_out, exp);
    endtask

    typedef struct {
        logic [31:0] wa, wd;
        logic [3:0]  be;
        logic [31:0] ra, ex;
    } vec_t;
    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{BASE + 16, 32'h1234_5678, 4'b0101, BASE + 16, 32'h0034_0078};
        tbl[1]  = '{BASE + 16, 32'hAB00_0000, 4'b1000, BASE + 16, 32'hAB34_0078};
        tbl[2]  = '{BASE + 20, 32'hFFFF_FFFF, 4'b1111, BASE + 20, 32'h0000_00FF};
        tbl[3]  = '{BASE + 20, 32'h0000_0000, 4'b0010, BASE + 20, 32'h0000_00FF};
        tbl[4]  = '{BASE + 20, 32'h0000_0000, 4'b0001, BASE + 20, 32'h0000_0000};
        tbl[5]  = '{BASE + 0,  32'hFFFF_FFFF, 4'b1111, BASE + 0,  32'h0000_0000};
        tbl[6]  = '{BASE + 8,  32'hFFFF_FFFF, 4'b1111, BASE + 8,  32'h0000_0000};
        tbl[7]  = '{BASE + 24, 32'hFFFF_FFFF, 4'b1111, BASE + 16, 32'hAB34_0078};
        tbl[8]  = '{BASE - 4,  32'hFFFF_FFFF, 4'b1111, BASE + 24, 32'h0000_0000};
        tbl[9]  = '{BASE + 12, 32'hFFFF_FFFF, 4'b1111, BASE + 12, 32'h0000_0000};
        tbl[10] = '{BASE + 19, 32'h0000_0000, 4'b1111, BASE + 16, 32'h0000_0000};
        tbl[11] = '{BASE + 16, 32'h1234_5678, 4'b0101, BASE + 16, 32'h0034_0078};
        tbl[12] = '{BASE + 16, 32'hFFFF_FFFF, 4'b0000, BASE + 17, 32'h0034_0078};

        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(6);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_led_n", led_n, 32'hFFFF_FFFF);
        rd(BASE + 16, 32'h0, "rst_led");
        rd(BASE + 12, 32'h0, "rst_edge");
        rd(BASE + 8, 32'h0, "rst_key");
        rd(BASE + 0, 32'h0, "rst_sw_lo");

        foreach (tbl[i]) begin
            wr(tbl[i].wa, tbl[i].wd, tbl[i].be);
            rd(tbl[i].ra, tbl[i].ex, $sformatf("vec%0d", i));
        end
        check("led_n_lanes", led_n, 32'hFFCB_FF87);

        dip_sw_n[7:0] = 8'hF0;
        dip_sw_n[63:56] = 8'h5A;
        cyc(1);
        rd(BASE, 32'h0, "sw_lo_1cyc");
        cyc(1);
        rd(BASE, 32'h0000_000F, "sw_lo");
        rd(BASE + 4, 32'hA500_0000, "sw_hi");

        wr(BASE + 20, 32'h4, 4'b0001);
`ifdef GPIO_DEBOUNCE_EN
        key_n[2] = 1'b0;
        cyc(3);
        key_n[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            rd(BASE + 8, 32'h0, "glitch_key");
        end
        rd(BASE + 12, 32'h0, "glitch_edge");
`endif
        key_n[2] = 1'b0;
        cyc(LAT - 1);
        rd(BASE + 8, 32'h0, "key_early");
        cyc(1);
        rd(BASE + 8, 32'h4, "key_set");
        rd(BASE + 12, 32'h4, "edge_set");
        check("irq_early", {31'b0, irq}, 32'h0);
        cyc(1);
        check("irq_set", {31'b0, irq}, 32'h1);
        cyc(4);
        key_n[2] = 1'b1;
        cyc(LAT + 4);

        wr(BASE + 12, 32'h4, 4'b0001);
        rd(BASE + 12, 32'h0, "w1c_clear");
        check("irq_hold", {31'b0, irq}, 32'h1);
        cyc(1);
        check("irq_drop", {31'b0, irq}, 32'h0);

        key_n[2] = 1'b0;
        cyc(LAT - 1);
        addr_in = BASE + 12; data_in = 32'h4; byteen = 4'b0001;
        cyc(1);
        byteen = '0;
        rd(BASE + 12, 32'h4, "w1c_race");
        cyc(1);
        check("irq_race", {31'b0, irq}, 32'h1);
        wr(BASE + 12, 32'h4, 4'b0001);
        rd(BASE + 12, 32'h0, "w1c_noedge");
        cyc(1);
        check("irq_drop2", {31'b0, irq}, 32'h0);
        key_n[2] = 1'b1;
        cyc(LAT + 4);

        key_n[0] = 1'b0;
        cyc(1);
        key_n[0] = 1'b1;
`ifdef GPIO_DEBOUNCE_EN
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            rd(BASE + 12, 32'h0, "pulse_filtered");
        end
`else
        rd(BASE + 12, 32'h0, "pulse_early");
        cyc(1);
        rd(BASE + 12, 32'h1, "pulse_edge");
`endif

        wr(BASE + 12, 32'hFF, 4'b0001);
        key_n[2] = 1'b0;
        cyc(LAT + 1);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        key_n[3] = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        check("rst_mid_led_n", led_n, 32'hFFFF_FFFF);
        check("rst_mid_irq", {31'b0, irq}, 32'h0);
        rd(BASE + 12, 32'h0, "rst_mid_edge");
        rd(BASE + 20, 32'h0, "rst_mid_mask");
        rd(BASE + 16, 32'h0, "rst_mid_led");
        reset = 1'b0;
        key_n = '1;
        cyc(LAT + 4);

        for (int n = 0; n < 3000; n++) begin
            int k, b;
            k = $urandom_range(0, 9);
            reset = ($urandom_range(0, 499) == 0);
            addr_in = (k < 6) ? BASE + 32'(4 * k) + 32'($urandom_range(0, 3)) :
                      (k < 8) ? BASE + 32'(4 * k) :
                      (k == 8) ? BASE - 32'd4 : 32'($urandom);
            data_in = $urandom;
            byteen = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 15) == 0) dip_sw_n = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, K - 1);
                key_n[b] = ~key_n[b];
            end
            cyc(1);
            check("rnd_data", data_out, m_read(addr_in));
            check("rnd_led_n", led_n, ~m_led);
            check("rnd_irq", {31'b0, irq}, {31'b0, m_irq});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
